// File: rtl/rename_pkg.sv
// rename_pkg: shared defaults and record types for the rename stage.
package rename_pkg;
  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PHYS_REGS = 64;
  localparam int DEF_CKPT = 4;
  localparam int DEF_PW = $clog2(DEF_PHYS_REGS);
  localparam int DEF_TW = $clog2(DEF_CKPT);
  typedef struct packed {
    logic valid;
    logic hit;
    logic [DEF_TW-1:0] tag;
  } br_result_t;
  typedef struct packed {
    logic valid;
    logic [DEF_PW-1:0] idx;
  } p_reg_t;
endpackage

// File: rtl/rename_ff1.sv
// rename_ff1: lowest-set-bit finder returning {found, idx}.
module rename_ff1 #(
  parameter int WIDTH = 8,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IW-1:0]    idx
);
  always_comb begin
    found = |vec;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) idx = IW'(i);
  end
endmodule

// File: rtl/rename_multi_ckpt.sv
// rename_multi_ckpt: RAT/free-list rename with nested branch checkpoints.
module rename_multi_ckpt
  import rename_pkg::*;
#(
  parameter int NUM_ARCH_REGS = DEF_ARCH_REGS,
  parameter int NUM_PHYS_REGS = DEF_PHYS_REGS,
  parameter int NUM_CKPT = DEF_CKPT,
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int PW = $clog2(NUM_PHYS_REGS),
  localparam int TW = $clog2(NUM_CKPT)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_rs1_valid_i,
  input  logic          in_rs2_valid_i,
  input  logic          in_rd_valid_i,
  input  logic [AW-1:0] in_rs1_i,
  input  logic [AW-1:0] in_rs2_i,
  input  logic [AW-1:0] in_rd_i,
  input  logic          in_is_branch_i,
  output logic          out_valid_o,
  output logic [PW-1:0] out_prs1_o,
  output logic [PW-1:0] out_prs2_o,
  output logic          out_prs1_rdy_o,
  output logic          out_prs2_rdy_o,
  output logic [PW-1:0] out_prd_o,
  output logic [PW-1:0] out_prd_old_o,
  output logic [TW-1:0] out_br_tag_o,
  input  logic          wb_valid_i,
  input  logic [PW-1:0] wb_preg_i,
  input  logic          commit_valid_i,
  input  logic [PW-1:0] commit_prd_old_i,
  input  logic          br_valid_i,
  input  logic          br_hit_i,
  input  logic [TW-1:0] br_tag_i
);
  logic [PW-1:0] rat_q [NUM_ARCH_REGS];
  logic [PW-1:0] rat_upd [NUM_ARCH_REGS];
  logic [PW-1:0] rat_n [NUM_ARCH_REGS];
  logic [PW-1:0] ckpt_rat [NUM_CKPT][NUM_ARCH_REGS];
  logic [NUM_PHYS_REGS-1:0] free_q, free_n, rdy_q, rdy_n;
  logic [NUM_PHYS_REGS-1:0] amask_q [NUM_CKPT];
  logic [NUM_PHYS_REGS-1:0] amask_n [NUM_CKPT];
  logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] older_n [NUM_CKPT];
  logic [NUM_CKPT-1:0] cv_q, cv_n;
  logic need_preg, pf_found, sf_found, accept, alloc_go, br_go, mispredict, hit;
  logic [PW-1:0] alloc;
  logic [TW-1:0] slot;
  rename_ff1 #(.WIDTH(NUM_PHYS_REGS)) u_pf (
    .vec  (free_q & ~NUM_PHYS_REGS'(1)),
    .found(pf_found),
    .idx  (alloc)
  );
  rename_ff1 #(.WIDTH(NUM_CKPT)) u_sf (
    .vec  (~cv_q),
    .found(sf_found),
    .idx  (slot)
  );
  assign need_preg = in_rd_valid_i && in_rd_i != '0;
  assign in_ready_o = !(need_preg && !pf_found) && !(in_is_branch_i && !sf_found)
                      && !(br_valid_i && !br_hit_i);
  assign accept = in_valid_i && in_ready_o;
  assign out_valid_o = accept;
  assign alloc_go = accept && need_preg;
  assign br_go = accept && in_is_branch_i;
  assign mispredict = br_valid_i && !br_hit_i && cv_q[br_tag_i];
  assign hit = br_valid_i && br_hit_i && cv_q[br_tag_i];
  assign out_prs1_o = (in_rs1_valid_i && in_rs1_i != '0) ? rat_q[in_rs1_i] : '0;
  assign out_prs2_o = (in_rs2_valid_i && in_rs2_i != '0) ? rat_q[in_rs2_i] : '0;
  assign out_prs1_rdy_o = rdy_q[out_prs1_o] || (wb_valid_i && wb_preg_i == out_prs1_o);
  assign out_prs2_rdy_o = rdy_q[out_prs2_o] || (wb_valid_i && wb_preg_i == out_prs2_o);
  assign out_prd_o = need_preg ? alloc : '0;
  assign out_prd_old_o = need_preg ? rat_q[in_rd_i] : '0;
  assign out_br_tag_o = slot;
  always_comb begin
    rat_upd = rat_q;
    if (alloc_go) rat_upd[in_rd_i] = alloc;
    rat_n = rat_upd;
    if (mispredict) rat_n = ckpt_rat[br_tag_i];
    free_n = free_q;
    if (alloc_go) free_n[alloc] = 1'b0;
    if (mispredict) free_n = free_n | amask_q[br_tag_i];
    if (commit_valid_i && commit_prd_old_i != '0) free_n[commit_prd_old_i] = 1'b1;
    rdy_n = rdy_q;
    if (alloc_go) rdy_n[alloc] = 1'b0;
    if (wb_valid_i && wb_preg_i != '0) rdy_n[wb_preg_i] = 1'b1;
    cv_n = cv_q;
    amask_n = amask_q;
    older_n = older_q;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (alloc_go && cv_q[k]) amask_n[k][alloc] = 1'b1;
      if (mispredict && (TW'(k) == br_tag_i || older_q[k][br_tag_i])) cv_n[k] = 1'b0;
    end
    if (br_go) begin
      cv_n[slot] = 1'b1;
      amask_n[slot] = '0;
      older_n[slot] = cv_q;
    end
    if (hit) cv_n[br_tag_i] = 1'b0;
    // a resolved slot is no longer anyone's ancestor
    if (hit || mispredict) for (int k = 0; k < NUM_CKPT; k++) older_n[k][br_tag_i] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rat_q[i] <= PW'(i);
      free_q <= {NUM_PHYS_REGS{1'b1}} << NUM_ARCH_REGS;
      rdy_q <= '1;
      cv_q <= '0;
      for (int k = 0; k < NUM_CKPT; k++) begin
        amask_q[k] <= '0;
        older_q[k] <= '0;
      end
    end else begin
      rat_q <= rat_n;
      free_q <= free_n;
      rdy_q <= rdy_n;
      cv_q <= cv_n;
      amask_q <= amask_n;
      older_q <= older_n;
    end
  end
  always_ff @(posedge clk) if (br_go) ckpt_rat[slot] <= rat_upd;
endmodule

// File: tb/tb_rename_multi_ckpt.sv
// tb_rename_multi_ckpt: directed vector table plus checkpoint recovery sequences.
module tb_rename_multi_ckpt;
  logic clk = 1'b0, rst_i;
  logic in_valid_i, in_ready_o, in_rs1_valid_i, in_rs2_valid_i, in_rd_valid_i, in_is_branch_i;
  logic [4:0] in_rs1_i, in_rs2_i, in_rd_i;
  logic out_valid_o, out_prs1_rdy_o, out_prs2_rdy_o;
  logic [5:0] out_prs1_o, out_prs2_o, out_prd_o, out_prd_old_o, wb_preg_i, commit_prd_old_i;
  logic [1:0] out_br_tag_o, br_tag_i;
  logic wb_valid_i, commit_valid_i, br_valid_i, br_hit_i;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rename_multi_ckpt dut (
    .clk(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rs1_valid_i(in_rs1_valid_i), .in_rs2_valid_i(in_rs2_valid_i), .in_rd_valid_i(in_rd_valid_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i), .in_is_branch_i(in_is_branch_i),
    .out_valid_o(out_valid_o), .out_prs1_o(out_prs1_o), .out_prs2_o(out_prs2_o),
    .out_prs1_rdy_o(out_prs1_rdy_o), .out_prs2_rdy_o(out_prs2_rdy_o), .out_prd_o(out_prd_o),
    .out_prd_old_o(out_prd_old_o), .out_br_tag_o(out_br_tag_o), .wb_valid_i(wb_valid_i),
    .wb_preg_i(wb_preg_i), .commit_valid_i(commit_valid_i), .commit_prd_old_i(commit_prd_old_i),
    .br_valid_i(br_valid_i), .br_hit_i(br_hit_i), .br_tag_i(br_tag_i)
  );
  typedef struct {
    int v, rdv, rd, rs1, rs2, br, wbv, wbp, cv, cp, bv, bh, bt;
    int rdy, ov, p1, r1, p2, r2, prd, old, tag;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid_i = 0; in_rs1_valid_i = 1; in_rs2_valid_i = 1; in_rd_valid_i = 0;
    in_rs1_i = 0; in_rs2_i = 0; in_rd_i = 0; in_is_branch_i = 0;
    wb_valid_i = 0; wb_preg_i = 0; commit_valid_i = 0; commit_prd_old_i = 0;
    br_valid_i = 0; br_hit_i = 0; br_tag_i = 0;
  endtask
  task automatic ren(input int rdv, input int rd, input int rs1, input int rs2, input int br);
    idle();
    in_valid_i = 1; in_rd_valid_i = 1'(rdv); in_rd_i = 5'(rd);
    in_rs1_i = 5'(rs1); in_rs2_i = 5'(rs2); in_is_branch_i = 1'(br);
  endtask
  task automatic do_reset();
    idle();
    rst_i = 1;
    #2;
    chk("reset_ready", int'(in_ready_o), 1);
    chk("reset_ovalid", int'(out_valid_o), 0);
    cyc();
    rst_i = 0;
  endtask
  initial begin
    tbl[0]  = '{0,0,0,  0,0,0, 0,0,  0,0,  0,0,0,  1,0,  0,1, 0,1,  0, 0, 0};
    tbl[1]  = '{1,1,5,  5,6,0, 0,0,  0,0,  0,0,0,  1,1,  5,1, 6,1, 32, 5, 0};
    tbl[2]  = '{1,1,7,  5,0,0, 0,0,  0,0,  0,0,0,  1,1, 32,0, 0,1, 33, 7, 0};
    tbl[3]  = '{1,0,9,  5,7,0, 1,32, 0,0,  0,0,0,  1,1, 32,1,33,0,  0, 0, 0};
    tbl[4]  = '{1,1,0,  5,7,0, 0,0,  0,0,  0,0,0,  1,1, 32,1,33,0,  0, 0, 0};
    tbl[5]  = '{1,1,5,  5,0,0, 0,0,  0,0,  0,0,0,  1,1, 32,1, 0,1, 34,32, 0};
    tbl[6]  = '{0,0,0,  0,0,0, 0,0,  1,32, 0,0,0,  1,0,  0,1, 0,1,  0, 0, 0};
    tbl[7]  = '{1,1,10, 5,0,0, 0,0,  0,0,  0,0,0,  1,1, 34,0, 0,1, 32,10, 0};
    tbl[8]  = '{1,1,11, 0,0,0, 0,0,  0,0,  1,0,0,  0,0,  0,1, 0,1, 35,11, 0};
    tbl[9]  = '{1,1,11, 0,0,0, 0,0,  0,0,  0,0,0,  1,1,  0,1, 0,1, 35,11, 0};
    tbl[10] = '{0,0,0,  0,0,0, 1,33, 0,0,  0,0,0,  1,0,  0,1, 0,1,  0, 0, 0};
    tbl[11] = '{1,0,0,  7,10,0,0,0,  0,0,  0,0,0,  1,1, 33,1,32,0,  0, 0, 0};
    idle();
    rst_i = 1;
    @(posedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ren(tbl[i].rdv, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].br);
      in_valid_i = 1'(tbl[i].v);
      wb_valid_i = 1'(tbl[i].wbv); wb_preg_i = 6'(tbl[i].wbp);
      commit_valid_i = 1'(tbl[i].cv); commit_prd_old_i = 6'(tbl[i].cp);
      br_valid_i = 1'(tbl[i].bv); br_hit_i = 1'(tbl[i].bh); br_tag_i = 2'(tbl[i].bt);
      #2;
      chk($sformatf("v%0d_ready", i), int'(in_ready_o), tbl[i].rdy);
      chk($sformatf("v%0d_ovalid", i), int'(out_valid_o), tbl[i].ov);
      chk($sformatf("v%0d_prs1", i), int'(out_prs1_o), tbl[i].p1);
      chk($sformatf("v%0d_rdy1", i), int'(out_prs1_rdy_o), tbl[i].r1);
      chk($sformatf("v%0d_prs2", i), int'(out_prs2_o), tbl[i].p2);
      chk($sformatf("v%0d_rdy2", i), int'(out_prs2_rdy_o), tbl[i].r2);
      chk($sformatf("v%0d_prd", i), int'(out_prd_o), tbl[i].prd);
      chk($sformatf("v%0d_prd_old", i), int'(out_prd_old_o), tbl[i].old);
      chk($sformatf("v%0d_tag", i), int'(out_br_tag_o), tbl[i].tag);
      cyc();
    end
    // free-list exhaustion and commit-to-allocate latency
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ren(1, (i % 31) + 1, 0, 0, 0);
      #2;
      chk($sformatf("fill%0d_ready", i), int'(in_ready_o), 1);
      chk($sformatf("fill%0d_prd", i), int'(out_prd_o), 32 + i);
      cyc();
    end
    ren(1, 1, 0, 0, 0);
    #2;
    chk("full_ready", int'(in_ready_o), 0);
    chk("full_ovalid", int'(out_valid_o), 0);
    cyc();
    commit_valid_i = 1; commit_prd_old_i = 5;
    #2;
    chk("commit_cycle_ready", int'(in_ready_o), 0);
    cyc();
    commit_valid_i = 0;
    #2;
    chk("after_commit_ready", int'(in_ready_o), 1);
    chk("after_commit_prd", int'(out_prd_o), 5);
    cyc();
    // nested mispredict on the outer branch, with a same-cycle commit
    do_reset();
    ren(0, 0, 0, 0, 1); #2; chk("nA_tag", int'(out_br_tag_o), 0); cyc();
    ren(1, 3, 0, 0, 0); #2; chk("nA_prd3", int'(out_prd_o), 32); cyc();
    ren(0, 0, 0, 0, 1); #2; chk("nB_tag", int'(out_br_tag_o), 1); cyc();
    ren(1, 4, 0, 0, 0); #2; chk("nB_prd4", int'(out_prd_o), 33); cyc();
    ren(1, 6, 0, 0, 0);
    br_valid_i = 1; br_hit_i = 0; br_tag_i = 0; commit_valid_i = 1; commit_prd_old_i = 7;
    #2;
    chk("mp_ready", int'(in_ready_o), 0);
    chk("mp_ovalid", int'(out_valid_o), 0);
    cyc();
    ren(1, 5, 3, 4, 1);
    #2;
    chk("rec_prs1", int'(out_prs1_o), 3);
    chk("rec_prs2", int'(out_prs2_o), 4);
    chk("rec_prd_commit", int'(out_prd_o), 7);
    chk("rec_tag", int'(out_br_tag_o), 0);
    cyc();
    ren(1, 6, 0, 0, 0); #2; chk("rec_prd32", int'(out_prd_o), 32); cyc();
    ren(1, 6, 0, 0, 0); #2; chk("rec_prd33", int'(out_prd_o), 33); cyc();
    // hit on outer, mispredict on inner
    do_reset();
    ren(0, 0, 0, 0, 1); #2; chk("hA_tag", int'(out_br_tag_o), 0); cyc();
    ren(1, 3, 0, 0, 0); #2; chk("hA_prd3", int'(out_prd_o), 32); cyc();
    ren(0, 0, 0, 0, 1); #2; chk("hB_tag", int'(out_br_tag_o), 1); cyc();
    ren(1, 4, 0, 0, 0); #2; chk("hB_prd4", int'(out_prd_o), 33); cyc();
    idle(); br_valid_i = 1; br_hit_i = 1; br_tag_i = 0;
    #2; chk("hit_ready", int'(in_ready_o), 1); cyc();
    idle(); br_valid_i = 1; br_hit_i = 0; br_tag_i = 1;
    #2; chk("mpB_ready", int'(in_ready_o), 0); cyc();
    ren(1, 7, 3, 4, 1);
    #2;
    chk("hm_prs1", int'(out_prs1_o), 32);
    chk("hm_prs2", int'(out_prs2_o), 4);
    chk("hm_prd", int'(out_prd_o), 33);
    chk("hm_tag", int'(out_br_tag_o), 0);
    cyc();
    // checkpoint slot exhaustion
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ren(0, 0, 0, 0, 1);
      #2;
      chk($sformatf("ck%0d_tag", i), int'(out_br_tag_o), i);
      chk($sformatf("ck%0d_ready", i), int'(in_ready_o), 1);
      cyc();
    end
    ren(0, 0, 0, 0, 1); #2; chk("ck_full_ready", int'(in_ready_o), 0); cyc();
    br_valid_i = 1; br_hit_i = 1; br_tag_i = 2;
    #2; chk("ck_hit_cycle_ready", int'(in_ready_o), 0); cyc();
    br_valid_i = 0;
    #2;
    chk("ck_reuse_ready", int'(in_ready_o), 1);
    chk("ck_reuse_tag", int'(out_br_tag_o), 2);
    cyc();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_multi_ckpt.md
# rename_multi_ckpt

Parametrised register-rename stage between decode and dispatch. It maps architectural to physical registers through a RAT and a free-list bitvector, and tracks per-physical-register ready bits that are set at writeback. It holds up to NUM_CKPT concurrent branch checkpoints for single-cycle misprediction recovery, including nested-branch squash. Old physical registers return to the free list at commit, not at rename.

## Interface
- NUM_ARCH_REGS, 32, architectural registers (x0 hardwired zero)
- NUM_PHYS_REGS, 64, physical registers; must be > NUM_ARCH_REGS
- NUM_CKPT, 4, branch checkpoint slots
- AW = $clog2(NUM_ARCH_REGS), PW = $clog2(NUM_PHYS_REGS), TW = $clog2(NUM_CKPT) (derived localparams)

Ports:
- clk  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- in_valid_i  in  1  decoded instruction valid
- in_ready_o  out  1  rename can accept this cycle
- in_rs1_valid_i, in_rs2_valid_i, in_rd_valid_i  in  1 each  operand-used flags
- in_rs1_i, in_rs2_i, in_rd_i  in  AW each  architectural indices
- in_is_branch_i  in  1  instruction needs a checkpoint
- out_valid_o  out  1  renamed instruction valid (in_valid_i && in_ready_o)
- out_prs1_o, out_prs2_o  out  PW each  physical sources
- out_prs1_rdy_o, out_prs2_rdy_o  out  1 each  source ready
- out_prd_o, out_prd_old_o  out  PW each  new and previous physical destination
- out_br_tag_o  out  TW  checkpoint slot allocated to this branch
- wb_valid_i  in  1  writeback valid;  wb_preg_i  in  PW  physical register written back
- commit_valid_i  in  1  in-order commit;  commit_prd_old_i  in  PW  register to free
- br_valid_i  in  1  branch resolved;  br_hit_i  in  1  prediction correct;  br_tag_i  in  TW  slot resolved

## Operation
- need_preg = in_rd_valid_i && in_rd_i != 0. Allocation takes the lowest-index free preg ≥1, chosen from the registered free list.
- in_ready_o = !(need_preg && no free preg) && !(in_is_branch_i && no free slot) && !(br_valid_i && !br_hit_i).
- Sources: idx 0 gives preg 0 with ready 1. Otherwise the output is rat[idx], and ready = ready_bit | (wb_valid_i && wb_preg_i == rat[idx]).
- Destination when need_preg:
  - prd = alloc, prd_old = rat[rd].
  - On accept: rat[rd] <= alloc, free[alloc] <= 0, ready[alloc] <= 0.
  - When rd is unused or rd = x0: prd = prd_old = 0, and no state changes.
- On every accepted allocation, set bit alloc in alloc_mask[k] for every valid checkpoint k.
- Branch accept:
  - Allocate the lowest free slot s and report it on out_br_tag_o.
  - ckpt_rat[s] <= RAT including this instruction's own rd update.
  - alloc_mask[s] <= 0, older_mask[s] <= current valid-slot vector, valid[s] <= 1.
- wb: ready[wb_preg_i] <= 1. Writes to preg 0 are ignored.
- Commit: free[commit_prd_old_i] <= 1 unless the value is 0.
- Hit (valid tag t): valid[t] <= 0 and bit t is cleared in every older_mask. If t is not valid, the event is ignored.
- Mispredict (valid tag t):
  - RAT <= ckpt_rat[t] and free |= alloc_mask[t].
  - Invalidate t and every slot j whose older_mask[j][t] is set.
  - Ready bits are unchanged.
  - If t is not valid, the event is ignored.
- Simultaneous events:
  - Commit and mispredict in the same cycle: both apply; the commit's freed bit is ORed in.
  - wb and mispredict in the same cycle: both apply.
  - A preg freed by commit is allocatable the next cycle, not the same cycle.
  - alloc_mask and RAT updates from a same-cycle accept cannot occur during a mispredict, because the accept is blocked.

## Timing
- Rename output is combinational, with zero latency from the in_* inputs. All state updates at posedge clk.
- Mispredict takes effect in one cycle. The first post-recovery instruction can be accepted the next cycle.
- Reset (asynchronous, while rst_i = 1):
  - RAT is identity.
  - Free list: pregs 0..NUM_ARCH_REGS-1 allocated, the rest free.
  - All ready bits are 1.
  - All checkpoints are invalid; masks are 0.
- Outputs during and after reset: out_valid_o = 0 when in_valid_i = 0; in_ready_o = 1.
- Reset asserted mid-operation discards all checkpoints and in-flight allocations with no further handshake.

## Structure
- rename_pkg holds:
  - default NUM_ARCH_REGS/NUM_PHYS_REGS/NUM_CKPT constants
  - br_result_t {valid, hit, tag}
  - p_reg_t {valid, idx}
- Sub-module rename_ff1: parametrised WIDTH lowest-set-bit finder producing {found, idx}.
  - Instantiated twice: once for the free list (bit 0 masked), once for the inverted checkpoint-valid vector.
- Checkpoint storage is flop arrays; no SRAM.

## Test plan
- After reset, rename of rd=5, rs1=5: prd=32, prd_old=5, prs1=5 rdy=1. The next instruction reading x5 gets prs1=32 rdy=0.
- wb preg 32 in the same cycle as a rename reading x5 gives rdy=1 (bypass). The next cycle the ready bit is registered.
- Allocate 32 pregs with no commits: in_ready_o=0 on the 33rd rd instruction. A commit of prd_old=5 frees preg 5, accepted one cycle later.
- Sequence: branch A (tag 0), rd=3 gets preg 32, branch B (tag 1), rd=4 gets preg 33, then mispredict on tag 0. Required result:
  - RAT x3=3, x4=4.
  - pregs 32 and 33 are free.
  - Both slots are invalid.
  - in_ready_o=0 during the mispredict cycle.
- Hit on tag 0, then mispredict on tag 1: only allocations after B are reclaimed. x3 keeps preg 32.
- Four branches outstanding with NUM_CKPT=4: a fifth branch stalls. A hit on tag 2 frees slot 2, and the fifth branch then receives tag 2.
